eth_tx_framer: RTL and testbench
================================

# eth_tx_framer

Single-clock Ethernet transmit framer for the 125 MHz GMII-style byte interface, the transmit counterpart of the receive path that feeds the 125→250 MHz CDC. It accepts a frame's payload (destination MAC through end of L2 payload) as a valid/ready byte stream and emits the complete wire frame on a byte-wide bus:

- preamble and SFD
- payload
- zero pad to the Ethernet minimum
- CRC-32 FCS
- enforced inter-packet gap

## Interface

**Parameters**

- `PREAMBLE_LEN`, 7: number of 0x55 bytes before SFD.
- `MIN_LEN`, 60: minimum bytes (payload + pad) before FCS.
- `MAX_LEN`, 1514: maximum payload bytes before forced truncation.
- `IFG_CYCLES`, 12: idle cycles after the final FCS byte.

**Ports**

- `clkIn`, in, 1: 125 MHz clock. One clock only; reset is synchronous and active-high.
- `rstIn`, in, 1: synchronous, active-high reset.
- `dataIn`, in, 8: payload byte.
- `dataValidIn`, in, 1: `dataIn` valid.
- `dataLastIn`, in, 1: final payload byte of the frame; qualified by valid.
- `dataReadyOut`, out, 1: framer accepts a byte this cycle.
- `txDataOut`, out, 8: wire byte (registered).
- `txEnOut`, out, 1: `txDataOut` is part of a frame (registered).
- `txErOut`, out, 1: current byte is corrupt; abort marker (registered).
- `busyOut`, out, 1: state ≠ IDLE.
- `errOut`, out, 1: one-cycle pulse on underrun or oversize.

## Operation

- **States:** IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG.
- **IDLE**
  - `dataReadyOut` is 0.
  - `dataValidIn` = 1 moves the block to PREAMBLE next cycle. The byte stays presented and is not consumed.
- **PREAMBLE:** drives 0x55 for `PREAMBLE_LEN` cycles, then moves to SFD.
- **SFD**
  - Drives 0xD5.
  - `dataReadyOut` = 1. A byte accepted here is driven in the first PAYLOAD cycle.
- **PAYLOAD**
  - `dataReadyOut` = 1 until the last byte has been accepted.
  - The byte accepted at cycle n (valid & ready) appears on `txDataOut` at cycle n+1.
  - The byte counter (11 bits) increments per accepted byte.
- **Underrun:** `dataValidIn` = 0 while ready = 1 in PAYLOAD.
  - Next cycle: `txEnOut` = 1, `txErOut` = 1, `txDataOut` = 0x00, `errOut` pulses.
  - Then go to IFG. No pad and no FCS are sent.
- **Oversize:** the `MAX_LEN`-th byte is accepted without `dataLastIn`.
  - That byte is treated as last and `errOut` pulses.
  - Following input bytes are not accepted (ready = 0) until the next frame.
- **After last accepted:**
  - Count < `MIN_LEN`: go to PAD and drive 0x00 until count = `MIN_LEN`, then go to FCS.
  - Otherwise: go directly to FCS.
- **FCS:** 4 bytes of `~crc`, LSB byte first.
- **IFG:** `txEnOut` = 0 for `IFG_CYCLES`, then IDLE. `dataValidIn` is ignored.
- **CRC-32**
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Updated on every payload and pad byte as it is driven. Not updated on preamble or SFD.
  - Reinitialised on leaving IFG and on reset.

## Timing

- **Reset (`rstIn` = 1 at any point, including mid-frame):**
  - Next edge: state IDLE.
  - `txDataOut` = 0x00; `txEnOut`, `txErOut`, `errOut`, `busyOut`, `dataReadyOut` all = 0.
  - Counters are cleared and the CRC returns to 0xFFFFFFFF.
  - A frame in flight is dropped without an error marker.
- **Latency:** valid seen in IDLE at cycle 0 produces:
  - cycles 1–7: 0x55
  - cycle 8: 0xD5
  - cycle 9: first payload byte (when accepted at cycle 8)
- **Frame length on the wire:** 8 + max(N, `MIN_LEN`) + 4 cycles of `txEnOut` = 1, followed by ≥ `IFG_CYCLES` cycles of `txEnOut` = 0.
- **Back-to-back frames:** valid held through IFG starts the next preamble at IFG-end + 1 (IDLE for one cycle).
- **Simultaneous valid and last:** on the first byte this yields a 1-byte payload, padded to 60.
- **Handshake:** `dataReadyOut` is combinational from state and flags. It never depends combinationally on `dataValidIn`.

## Structure

- **`eth_pkg`:** state enum `txState_t`, constants `PREAMBLE_BYTE` = 8'h55, `SFD_BYTE` = 8'hD5, `CRC_POLY` = 32'hEDB88320, `CRC_INIT` = 32'hFFFFFFFF.
- **Sub-module `eth_crc32`:**
  - Byte-wide combinational-next / registered CRC.
  - Ports: `clkIn`, `rstIn`, `initIn`, `enIn`, `dataIn[7:0]`, `crcOut[31:0]`.
  - Reused by the future receive-side FCS checker.

## Test plan

- `eth_crc32` unit test: bytes "123456789" → `~crcOut` = 0xCBF43926, emitted by the framer as 0x26 0x39 0xF4 0xCB.
- 64-byte payload 0x00..0x3F with continuous valid:
  - wire shows 7×0x55, 0xD5, 0x00..0x3F, then an FCS equal to the bench model;
  - no pad; `txEnOut` high for 76 cycles; then 12 idle cycles.
- 1-byte payload 0xAB (valid and last together):
  - 0xAB, then 59×0x00 pad, then FCS computed over 60 bytes;
  - `txEnOut` high for 72 cycles.
- Underrun: drop valid after 20 payload bytes → next cycle `txErOut` = 1 and `errOut` pulse; no FCS; IFG follows.
- Back-to-back: two 60-byte frames with valid held → exactly 12 cycles with `txEnOut` = 0, plus 1 IDLE cycle, between them.
- Reset asserted during FCS byte 2 → next cycle all outputs 0 and state IDLE; the next frame is correct from preamble onwards.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types, constants and CRC helper for the Ethernet transmit path.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PAYLOAD,
        PAD,
        FCS,
        IFG
    } txState_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    // One byte of reflected CRC-32, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_framer_if.sv
// Payload stream in and GMII-style byte bus out of the transmit framer.
interface eth_tx_framer_if;

    logic [7:0] dataIn;
    logic       dataValidIn;
    logic       dataLastIn;
    logic       dataReadyOut;
    logic [7:0] txDataOut;
    logic       txEnOut;
    logic       txErOut;
    logic       busyOut;
    logic       errOut;

    modport master (
        output dataIn, dataValidIn, dataLastIn,
        input  dataReadyOut, txDataOut, txEnOut, txErOut, busyOut, errOut
    );

    modport slave (
        input  dataIn, dataValidIn, dataLastIn,
        output dataReadyOut, txDataOut, txEnOut, txErOut, busyOut, errOut
    );

endinterface

// File: rtl/eth_crc32.sv
// Byte-wide CRC-32 register; shared with the receive-side FCS checker.
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        initIn,
    input  logic        enIn,
    input  logic [7:0]  dataIn,
    output logic [31:0] crcOut
);

    logic [31:0] crc_next;

    // Next CRC value for the byte on dataIn.
    always_comb begin
        crc_next = crc32_byte(crcOut, dataIn);
    end

    // Running CRC; init has priority over enable.
    always_ff @(posedge clkIn) begin
        if (rstIn || initIn) begin
            crcOut <= CRC_INIT;
        end else if (enIn) begin
            crcOut <= crc_next;
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble/SFD, payload, zero pad, FCS and IFG.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_LEN      = 60,
    parameter int unsigned MAX_LEN      = 1514,
    parameter int unsigned IFG_CYCLES   = 12
) (
    input  logic            clkIn,
    input  logic            rstIn,
    eth_tx_framer_if.slave  bus
);

    localparam int unsigned BYTE_CNT_W  = 11;
    localparam int unsigned PHASE_CNT_W = 8;

    txState_t                 state;
    logic [PHASE_CNT_W-1:0]   phase_cnt;
    logic [BYTE_CNT_W-1:0]    byte_cnt;
    logic                     last_seen;
    logic [7:0]               tx_data;
    logic                     tx_en;
    logic                     tx_er;
    logic                     err;

    logic                     ready_c;
    logic                     accept_c;
    logic                     pad_c;
    logic                     last_byte_c;
    logic                     crc_en_c;
    logic                     crc_init_c;
    logic [7:0]               crc_data_c;
    logic [31:0]              crc;
    logic [31:0]              fcs_c;

    // Handshake and CRC feed, derived from registered state only (plus data for the CRC).
    always_comb begin
        ready_c     = (state == SFD) || ((state == PAYLOAD) && !last_seen);
        accept_c    = ready_c && bus.dataValidIn;
        pad_c       = (((state == PAYLOAD) && last_seen) || (state == PAD))
                      && (byte_cnt < BYTE_CNT_W'(MIN_LEN));
        last_byte_c = bus.dataLastIn || (byte_cnt == BYTE_CNT_W'(MAX_LEN - 1));
        crc_en_c    = accept_c || pad_c;
        crc_data_c  = accept_c ? bus.dataIn : 8'h00;
        crc_init_c  = (state == IFG) && !tx_en
                      && (phase_cnt == PHASE_CNT_W'(IFG_CYCLES - 1));
        fcs_c       = ~crc;
    end

    eth_crc32 u_crc (
        .clkIn  (clkIn),
        .rstIn  (rstIn),
        .initIn (crc_init_c),
        .enIn   (crc_en_c),
        .dataIn (crc_data_c),
        .crcOut (crc)
    );

    // Framing FSM; state always names the byte currently on the wire.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state     <= IDLE;
            phase_cnt <= '0;
            byte_cnt  <= '0;
            last_seen <= 1'b0;
            tx_data   <= 8'h00;
            tx_en     <= 1'b0;
            tx_er     <= 1'b0;
            err       <= 1'b0;
        end else begin
            err   <= 1'b0;
            tx_er <= 1'b0;
            case (state)
                IDLE: begin
                    tx_en   <= 1'b0;
                    tx_data <= 8'h00;
                    if (bus.dataValidIn) begin
                        state     <= PREAMBLE;
                        phase_cnt <= '0;
                        byte_cnt  <= '0;
                        last_seen <= 1'b0;
                        tx_en     <= 1'b1;
                        tx_data   <= PREAMBLE_BYTE;
                    end
                end
                PREAMBLE: begin
                    if (phase_cnt == PHASE_CNT_W'(PREAMBLE_LEN - 1)) begin
                        state   <= SFD;
                        tx_data <= SFD_BYTE;
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_CNT_W'(1);
                        tx_data   <= PREAMBLE_BYTE;
                    end
                end
                SFD, PAYLOAD, PAD: begin
                    if (ready_c) begin
                        if (bus.dataValidIn) begin
                            state    <= PAYLOAD;
                            tx_data  <= bus.dataIn;
                            byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                            if (last_byte_c) begin
                                last_seen <= 1'b1;
                                err       <= !bus.dataLastIn;
                            end
                        end else begin
                            // Underrun: one abort byte, then straight to the gap.
                            state     <= IFG;
                            phase_cnt <= '0;
                            tx_data   <= 8'h00;
                            tx_er     <= 1'b1;
                            err       <= 1'b1;
                        end
                    end else if (pad_c) begin
                        state    <= PAD;
                        tx_data  <= 8'h00;
                        byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                    end else begin
                        state     <= FCS;
                        phase_cnt <= '0;
                        last_seen <= 1'b0;
                        tx_data   <= fcs_c[7:0];
                    end
                end
                FCS: begin
                    if (phase_cnt[1:0] == 2'd3) begin
                        state     <= IFG;
                        phase_cnt <= '0;
                        tx_en     <= 1'b0;
                        tx_data   <= 8'h00;
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_CNT_W'(1);
                        case (phase_cnt[1:0])
                            2'd0:    tx_data <= fcs_c[15:8];
                            2'd1:    tx_data <= fcs_c[23:16];
                            default: tx_data <= fcs_c[31:24];
                        endcase
                    end
                end
                IFG: begin
                    tx_en   <= 1'b0;
                    tx_data <= 8'h00;
                    // The abort byte of an underrun does not count towards the gap.
                    if (!tx_en) begin
                        if (phase_cnt == PHASE_CNT_W'(IFG_CYCLES - 1)) begin
                            state     <= IDLE;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + PHASE_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dataReadyOut = ready_c;
    assign bus.txDataOut    = tx_data;
    assign bus.txEnOut      = tx_en;
    assign bus.txErOut      = tx_er;
    assign bus.busyOut      = (state != IDLE);
    assign bus.errOut       = err;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer plus a standalone eth_crc32 check.
module tb_eth_tx_framer;

    typedef struct packed {
        logic [7:0] data;
        logic       er;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b0;

    logic        crc_init = 1'b0;
    logic        crc_en = 1'b0;
    logic [7:0]  crc_data = 8'h00;
    logic [31:0] crc_out;

    eth_tx_framer_if bus();

    eth_tx_framer dut (
        .clkIn (clk),
        .rstIn (rst),
        .bus   (bus)
    );

    eth_crc32 u_crc (
        .clkIn  (clk),
        .rstIn  (rst),
        .initIn (crc_init),
        .enIn   (crc_en),
        .dataIn (crc_data),
        .crcOut (crc_out)
    );

    always #4 clk = ~clk;

    always @(posedge clk) rst_q <= rst;

    int   checks = 0;
    int   failures = 0;
    int   exp_err = 0;
    int   err_seen = 0;
    exp_t exp_q[$];
    int   gap_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h00000000);
        end
        return r;
    endfunction

    // Expected wire image of one frame.
    task automatic push_frame(input logic [7:0] p[$], input bit underrun, input bit oversize);
        logic [31:0] c;
        int          n;
        c = 32'hFFFFFFFF;
        n = p.size();
        for (int i = 0; i < 7; i++) exp_q.push_back('{8'h55, 1'b0, 1'b0});
        exp_q.push_back('{8'hD5, 1'b0, 1'b0});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{p[i], 1'b0, (oversize && (i == n - 1))});
            c = model_crc(c, p[i]);
        end
        if (underrun) begin
            exp_q.push_back('{8'h00, 1'b1, 1'b1});
            exp_err++;
            return;
        end
        if (oversize) exp_err++;
        for (int i = n; i < 60; i++) begin
            exp_q.push_back('{8'h00, 1'b0, 1'b0});
            c = model_crc(c, 8'h00);
        end
        c = ~c;
        exp_q.push_back('{c[7:0],   1'b0, 1'b0});
        exp_q.push_back('{c[15:8],  1'b0, 1'b0});
        exp_q.push_back('{c[23:16], 1'b0, 1'b0});
        exp_q.push_back('{c[31:24], 1'b0, 1'b0});
    endtask

    // Stream a payload; returns just after the last accepted byte.
    task automatic send_frame(input logic [7:0] p[$], input bit with_last, input bit keep);
        int idx;
        int n;
        int guard;
        bit acc;
        n = p.size();
        idx = 0;
        guard = 0;
        bus.dataValidIn = 1'b1;
        bus.dataIn = p[0];
        bus.dataLastIn = with_last && (n == 1);
        while (idx < n && guard < 5000) begin
            @(negedge clk);
            acc = bus.dataReadyOut;
            @(posedge clk);
            #1;
            guard++;
            if (acc) begin
                idx++;
                if (idx < n) begin
                    bus.dataIn = p[idx];
                    bus.dataLastIn = with_last && (idx == n - 1);
                end
            end
        end
        if (idx < n) timeout_fail("source_accept");
        if (!keep) begin
            bus.dataValidIn = 1'b0;
            bus.dataLastIn = 1'b0;
            bus.dataIn = 8'h00;
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(exp_q.size() == 0 && !bus.busyOut) && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 5000) timeout_fail("wait_idle");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every txEn byte, checks gaps and reset state.
    int gap = 0;
    bit in_frame = 1'b0;
    bit had_frame = 1'b0;
    int byte_idx = 0;
    always @(negedge clk) begin
        exp_t e;
        int   g;
        if (rst_q) begin
            chk("reset_outputs",
                {19'h0, bus.txDataOut, bus.txEnOut, bus.txErOut, bus.errOut, bus.busyOut, bus.dataReadyOut},
                32'h0);
        end else begin
            if (bus.errOut) err_seen++;
            if (bus.txEnOut) begin
                if (!in_frame && had_frame) begin
                    checks++;
                    if (gap < 12) begin
                        failures++;
                        $display("FAIL ifg_min actual=%0d required>=12", gap);
                    end
                    if (gap_q.size() != 0) begin
                        g = gap_q.pop_front();
                        chk("ifg_exact", 32'(gap), 32'(g));
                    end
                end
                in_frame = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=0x%0h required=no_byte", bus.txDataOut);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("wire_byte[%0d]", byte_idx),
                        {22'h0, bus.txDataOut, bus.txErOut, bus.errOut}, {22'h0, e});
                end
                byte_idx++;
            end else begin
                if (in_frame) begin
                    in_frame = 1'b0;
                    had_frame = 1'b1;
                    gap = 0;
                end
                gap++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] pl2[$];
        logic [7:0] digits[9];
        int         guard;

        bus.dataIn = 8'h00;
        bus.dataValidIn = 1'b0;
        bus.dataLastIn = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Standalone CRC: reset value and the "123456789" check value.
        chk("crc_reset", crc_out, 32'hFFFFFFFF);
        digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        crc_init = 1'b1;
        @(posedge clk); #1;
        crc_init = 1'b0;
        for (int i = 0; i < 9; i++) begin
            crc_en = 1'b1;
            crc_data = digits[i];
            @(posedge clk); #1;
        end
        crc_en = 1'b0;
        chk("crc_check", ~crc_out, 32'hCBF43926);

        // 64-byte frame, no pad.
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(i));
        push_frame(pl, 1'b0, 1'b0);
        send_frame(pl, 1'b1, 1'b0);
        wait_idle();

        // 1-byte frame, padded to 60.
        pl.delete();
        pl.push_back(8'hAB);
        push_frame(pl, 1'b0, 1'b0);
        send_frame(pl, 1'b1, 1'b0);
        wait_idle();

        // Underrun after 20 payload bytes.
        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'(8'hC0 + i));
        push_frame(pl, 1'b1, 1'b0);
        send_frame(pl, 1'b0, 1'b0);
        wait_idle();

        // Back-to-back 60-byte frames with valid held.
        pl.delete();
        pl2.delete();
        for (int i = 0; i < 60; i++) begin
            pl.push_back(8'(8'h80 + i));
            pl2.push_back(8'(i) ^ 8'h5A);
        end
        push_frame(pl, 1'b0, 1'b0);
        send_frame(pl, 1'b1, 1'b1);
        gap_q.push_back(13);
        push_frame(pl2, 1'b0, 1'b0);
        send_frame(pl2, 1'b1, 1'b0);
        wait_idle();

        // Oversize: MAX_LEN bytes without last, extra byte must not be taken.
        pl.delete();
        for (int i = 0; i < 1514; i++) pl.push_back(8'((i * 7) & 8'hFF));
        push_frame(pl, 1'b0, 1'b1);
        send_frame(pl, 1'b0, 1'b1);
        bus.dataIn = 8'hEE;
        repeat (5) @(posedge clk);
        #1;
        bus.dataValidIn = 1'b0;
        bus.dataIn = 8'h00;
        wait_idle();

        // Reset during the third FCS byte, then a clean frame.
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(8'hFF - i));
        push_frame(pl, 1'b0, 1'b0);
        send_frame(pl, 1'b1, 1'b0);
        guard = 0;
        while (exp_q.size() != 2 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 100) timeout_fail("reset_point");
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (20) @(posedge clk);
        #1;
        pl.delete();
        for (int i = 0; i < 61; i++) pl.push_back(8'(8'h10 + i));
        push_frame(pl, 1'b0, 1'b0);
        send_frame(pl, 1'b1, 1'b0);
        wait_idle();
        repeat (15) @(posedge clk);
        #1;

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("gap_queue_drained", 32'(gap_q.size()), 32'd0);
        chk("err_pulses", 32'(err_seen), 32'(exp_err));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
